// File: rtl/obi_pkg.sv
// Shared OBI field widths, the controller-port ID type and the round-robin
// wrap helper used by the 3-to-1 OBI mux and its ID FIFO.
package obi_pkg;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int BE_W     = 4;
  localparam int NUM_CTRL = 3;

  typedef logic [1:0] id_t;

  // (p + k) mod NUM_CTRL, used for the round-robin scan and pointer advance.
  function automatic id_t port_add(input id_t p, input int k);
    return id_t'((int'(p) + k) % NUM_CTRL);
  endfunction

endpackage

// File: rtl/obi_mux_id_fifo.sv
// Synchronous FIFO of controller IDs, one entry per granted transaction still
// awaiting its response; the head names the controller owed the next rvalid.
module obi_mux_id_fifo
  import obi_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  id_t  push_id,
  input  logic pop,
  output logic full,
  output logic empty,
  output id_t  head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  id_t              mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= ptr_inc(wptr);
      if (do_pop)  rptr <= ptr_inc(rptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage holds data only; validity is tracked by count, so no reset here.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_id;
  end

endmodule

// File: rtl/obi_mux_3_to_1.sv
// Round-robin arbiter of three OBI controllers onto one OBI device port, with
// an address-phase lock under backpressure and in-order response routing.
module obi_mux_3_to_1
  import obi_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ctrl0_req_i,
  output logic              ctrl0_gnt_o,
  input  logic [ADDR_W-1:0] ctrl0_addr_i,
  input  logic              ctrl0_we_i,
  input  logic [BE_W-1:0]   ctrl0_be_i,
  input  logic [DATA_W-1:0] ctrl0_wdata_i,
  output logic              ctrl0_rvalid_o,
  output logic [DATA_W-1:0] ctrl0_rdata_o,
  input  logic              ctrl1_req_i,
  output logic              ctrl1_gnt_o,
  input  logic [ADDR_W-1:0] ctrl1_addr_i,
  input  logic              ctrl1_we_i,
  input  logic [BE_W-1:0]   ctrl1_be_i,
  input  logic [DATA_W-1:0] ctrl1_wdata_i,
  output logic              ctrl1_rvalid_o,
  output logic [DATA_W-1:0] ctrl1_rdata_o,
  input  logic              ctrl2_req_i,
  output logic              ctrl2_gnt_o,
  input  logic [ADDR_W-1:0] ctrl2_addr_i,
  input  logic              ctrl2_we_i,
  input  logic [BE_W-1:0]   ctrl2_be_i,
  input  logic [DATA_W-1:0] ctrl2_wdata_i,
  output logic              ctrl2_rvalid_o,
  output logic [DATA_W-1:0] ctrl2_rdata_o,
  output logic              dev_req_o,
  input  logic              dev_gnt_i,
  output logic [ADDR_W-1:0] dev_addr_o,
  output logic              dev_we_o,
  output logic [BE_W-1:0]   dev_be_o,
  output logic [DATA_W-1:0] dev_wdata_o,
  input  logic              dev_rvalid_i,
  input  logic [DATA_W-1:0] dev_rdata_i,
  output logic              spurious_rvalid_o
);

  logic [NUM_CTRL-1:0] req;
  logic [NUM_CTRL-1:0] we;
  logic [ADDR_W-1:0]   addr  [NUM_CTRL];
  logic [BE_W-1:0]     be    [NUM_CTRL];
  logic [DATA_W-1:0]   wdata [NUM_CTRL];
  logic [NUM_CTRL-1:0] gnt;
  logic [NUM_CTRL-1:0] rvalid;

  id_t  rr_ptr;
  id_t  lock_sel;
  logic lock;
  id_t  sel;
  logic sel_vld;
  id_t  head;
  logic full;
  logic empty;
  logic accept;
  logic pop;

  assign req      = {ctrl2_req_i, ctrl1_req_i, ctrl0_req_i};
  assign we       = {ctrl2_we_i, ctrl1_we_i, ctrl0_we_i};
  assign addr[0]  = ctrl0_addr_i;
  assign addr[1]  = ctrl1_addr_i;
  assign addr[2]  = ctrl2_addr_i;
  assign be[0]    = ctrl0_be_i;
  assign be[1]    = ctrl1_be_i;
  assign be[2]    = ctrl2_be_i;
  assign wdata[0] = ctrl0_wdata_i;
  assign wdata[1] = ctrl1_wdata_i;
  assign wdata[2] = ctrl2_wdata_i;

  // Arbitration, address-phase mux and response routing are all combinational.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    if (!full) begin
      if (lock) begin
        sel     = lock_sel;
        sel_vld = 1'b1;
      end else begin
        for (int i = 0; i < NUM_CTRL; i++) begin
          if (!sel_vld && req[port_add(rr_ptr, i)]) begin
            sel     = port_add(rr_ptr, i);
            sel_vld = 1'b1;
          end
        end
      end
    end

    dev_req_o   = sel_vld & req[sel] & ~rst_i;
    dev_addr_o  = sel_vld ? addr[sel]  : '0;
    dev_we_o    = sel_vld ? we[sel]    : 1'b0;
    dev_be_o    = sel_vld ? be[sel]    : '0;
    dev_wdata_o = sel_vld ? wdata[sel] : '0;

    gnt = '0;
    if (dev_req_o) gnt[sel] = dev_gnt_i;

    rvalid = '0;
    if (dev_rvalid_i && !empty && !rst_i) rvalid[head] = 1'b1;
    spurious_rvalid_o = dev_rvalid_i & empty & ~rst_i;
  end

  assign accept = dev_req_o & dev_gnt_i;
  assign pop    = dev_rvalid_i & ~empty;

  assign ctrl0_gnt_o    = gnt[0];
  assign ctrl1_gnt_o    = gnt[1];
  assign ctrl2_gnt_o    = gnt[2];
  assign ctrl0_rvalid_o = rvalid[0];
  assign ctrl1_rvalid_o = rvalid[1];
  assign ctrl2_rvalid_o = rvalid[2];
  assign ctrl0_rdata_o  = dev_rdata_i;
  assign ctrl1_rdata_o  = dev_rdata_i;
  assign ctrl2_rdata_o  = dev_rdata_i;

  // A request left ungranted pins the selection until the handshake completes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr <= '0;
      lock   <= 1'b0;
    end else begin
      lock <= dev_req_o & ~dev_gnt_i;
      if (accept) rr_ptr <= port_add(sel, 1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (dev_req_o && !dev_gnt_i) lock_sel <= sel;
  end

  obi_mux_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .CNT_W (CNT_W)
  ) u_id_fifo (
    .clk     (clk_i),
    .rst     (rst_i),
    .push    (accept),
    .push_id (sel),
    .pop     (pop),
    .full    (full),
    .empty   (empty),
    .head    (head)
  );

endmodule

// File: tb/tb_obi_mux_3_to_1.sv
// Bench for obi_mux_3_to_1: directed vector table, a lock sequence, and random
// OBI-compliant traffic against a queue-based reference model.
module tb_obi_mux_3_to_1;
  localparam int MAXO = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [2:0]  we;
  logic [31:0] addr [3];
  logic [3:0]  be [3];
  logic [31:0] wdata [3];
  logic [2:0]  gnt_o;
  logic [2:0]  rv_o;
  logic [31:0] rd0, rd1, rd2;
  logic        dev_req, dev_gnt, dev_we, dev_rvalid, spur;
  logic [31:0] dev_addr, dev_wdata, dev_rdata;
  logic [3:0]  dev_be;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  obi_mux_3_to_1 #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk), .rst_i(rst),
    .ctrl0_req_i(req[0]), .ctrl0_gnt_o(gnt_o[0]), .ctrl0_addr_i(addr[0]), .ctrl0_we_i(we[0]),
    .ctrl0_be_i(be[0]), .ctrl0_wdata_i(wdata[0]), .ctrl0_rvalid_o(rv_o[0]), .ctrl0_rdata_o(rd0),
    .ctrl1_req_i(req[1]), .ctrl1_gnt_o(gnt_o[1]), .ctrl1_addr_i(addr[1]), .ctrl1_we_i(we[1]),
    .ctrl1_be_i(be[1]), .ctrl1_wdata_i(wdata[1]), .ctrl1_rvalid_o(rv_o[1]), .ctrl1_rdata_o(rd1),
    .ctrl2_req_i(req[2]), .ctrl2_gnt_o(gnt_o[2]), .ctrl2_addr_i(addr[2]), .ctrl2_we_i(we[2]),
    .ctrl2_be_i(be[2]), .ctrl2_wdata_i(wdata[2]), .ctrl2_rvalid_o(rv_o[2]), .ctrl2_rdata_o(rd2),
    .dev_req_o(dev_req), .dev_gnt_i(dev_gnt), .dev_addr_o(dev_addr), .dev_we_o(dev_we),
    .dev_be_o(dev_be), .dev_wdata_o(dev_wdata), .dev_rvalid_i(dev_rvalid), .dev_rdata_i(dev_rdata),
    .spurious_rvalid_o(spur)
  );

  typedef struct {
    logic        rst;
    logic [2:0]  req;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic [7:0]  exp_st;   // {dev_req, gnt[2:0], rvalid[2:0], spurious}
    int          exp_sel;  // -1: address-phase fields must be zero
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic [2:0] rq, input logic g, input logic v,
                              input logic [31:0] rd, input logic dr, input logic [2:0] eg,
                              input logic [2:0] ev, input logic es, input int s);
    vec_t t;
    t.rst = r; t.req = rq; t.gnt = g; t.rv = v; t.rdata = rd;
    t.exp_st = {dr, eg, ev, es}; t.exp_sel = s;
    return t;
  endfunction

  function automatic logic [7:0] status();
    return {dev_req, gnt_o, rv_o, spur};
  endfunction

  task automatic chk_fields(input string tag, input int s);
    logic [31:0] ea, ew;
    logic [3:0]  eb;
    logic        ewe;
    ea = 0; ew = 0; eb = 0; ewe = 0;
    if (s >= 0) begin ea = addr[s]; ew = wdata[s]; eb = be[s]; ewe = we[s]; end
    chk({tag, "_addr"}, 64'(dev_addr), 64'(ea));
    chk({tag, "_wfields"}, 64'({dev_we, dev_be, dev_wdata}), 64'({ewe, eb, ew}));
  endtask

  task automatic set_fixed_fields();
    addr[0] = 32'h0000_0A00; addr[1] = 32'h0000_1000; addr[2] = 32'h0000_2000;
    we = 3'b101; be[0] = 4'h1; be[1] = 4'h3; be[2] = 4'hF;
    wdata[0] = 32'h1111_1111; wdata[1] = 32'h2222_2222; wdata[2] = 32'h3333_3333;
  endtask

  task automatic drive(input logic r, input logic [2:0] rq, input logic g, input logic v,
                       input logic [31:0] rd);
    @(negedge clk);
    rst = r; req = rq; dev_gnt = g; dev_rvalid = v; dev_rdata = rd;
    #1;
  endtask

  // Reference model state for the random phase
  int          q[$];
  int          m_ptr;
  int          m_held;
  logic [2:0]  pend;

  initial begin
    rst = 1'b1; req = '0; dev_gnt = 0; dev_rvalid = 0; dev_rdata = '0;
    set_fixed_fields();

    // Directed table: spurious, single read, round robin, full stall, reset mid-flight
    tbl.push_back(mk(1, 3'b111, 1, 1, 32'h0,        0, 3'b000, 3'b000, 0, -1));
    tbl.push_back(mk(0, 3'b000, 0, 1, 32'h0,        0, 3'b000, 3'b000, 1, -1));
    tbl.push_back(mk(0, 3'b000, 0, 0, 32'h0,        0, 3'b000, 3'b000, 0, -1));
    tbl.push_back(mk(0, 3'b010, 1, 0, 32'h0,        1, 3'b010, 3'b000, 0, 1));
    tbl.push_back(mk(0, 3'b000, 0, 0, 32'h0,        0, 3'b000, 3'b000, 0, -1));
    tbl.push_back(mk(0, 3'b000, 0, 1, 32'hCAFEF00D, 0, 3'b000, 3'b010, 0, -1));
    tbl.push_back(mk(1, 3'b000, 0, 0, 32'h0,        0, 3'b000, 3'b000, 0, -1));
    tbl.push_back(mk(0, 3'b111, 1, 0, 32'h0,        1, 3'b001, 3'b000, 0, 0));
    tbl.push_back(mk(0, 3'b111, 1, 1, 32'hA0A0_0001, 1, 3'b010, 3'b001, 0, 1));
    tbl.push_back(mk(0, 3'b111, 1, 1, 32'hA0A0_0002, 1, 3'b100, 3'b010, 0, 2));
    tbl.push_back(mk(0, 3'b111, 1, 1, 32'hA0A0_0003, 1, 3'b001, 3'b100, 0, 0));
    tbl.push_back(mk(0, 3'b111, 1, 1, 32'hA0A0_0004, 1, 3'b010, 3'b001, 0, 1));
    tbl.push_back(mk(0, 3'b111, 1, 0, 32'h0,        1, 3'b100, 3'b000, 0, 2));
    tbl.push_back(mk(0, 3'b111, 1, 0, 32'h0,        0, 3'b000, 3'b000, 0, -1));
    tbl.push_back(mk(0, 3'b111, 1, 1, 32'h5555_0001, 0, 3'b000, 3'b010, 0, -1));
    tbl.push_back(mk(0, 3'b111, 1, 0, 32'h0,        1, 3'b001, 3'b000, 0, 0));
    tbl.push_back(mk(0, 3'b000, 0, 1, 32'h5555_0002, 0, 3'b000, 3'b100, 0, -1));
    tbl.push_back(mk(0, 3'b000, 0, 1, 32'h5555_0003, 0, 3'b000, 3'b001, 0, -1));
    tbl.push_back(mk(0, 3'b000, 0, 1, 32'h5555_0004, 0, 3'b000, 3'b000, 1, -1));
    tbl.push_back(mk(0, 3'b100, 1, 0, 32'h0,        1, 3'b100, 3'b000, 0, 2));
    tbl.push_back(mk(0, 3'b010, 1, 0, 32'h0,        1, 3'b010, 3'b000, 0, 1));
    tbl.push_back(mk(1, 3'b110, 1, 1, 32'h0,        0, 3'b000, 3'b000, 0, -1));
    tbl.push_back(mk(0, 3'b110, 1, 0, 32'h0,        1, 3'b010, 3'b000, 0, 1));
    tbl.push_back(mk(0, 3'b100, 1, 1, 32'h7777_0001, 1, 3'b100, 3'b010, 0, 2));
    tbl.push_back(mk(0, 3'b000, 0, 1, 32'h7777_0002, 0, 3'b000, 3'b100, 0, -1));
    tbl.push_back(mk(0, 3'b000, 0, 1, 32'h7777_0003, 0, 3'b000, 3'b000, 1, -1));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].req, tbl[i].gnt, tbl[i].rv, tbl[i].rdata);
      chk($sformatf("vec%0d_status", i), 64'(status()), 64'(tbl[i].exp_st));
      chk($sformatf("vec%0d_rdata", i), 64'({rd0 ^ rd1, rd2}), 64'({32'h0, tbl[i].rdata}));
      if (!tbl[i].rst) chk_fields($sformatf("vec%0d", i), tbl[i].exp_sel);
    end

    // Lock under backpressure: ctrl2 stalls while ctrl0 joins on the second cycle
    drive(1, 3'b000, 0, 0, 0);
    drive(0, 3'b100, 0, 0, 0);
    chk("lock_c1_status", 64'(status()), 64'(8'b1_000_000_0));
    chk_fields("lock_c1", 2);
    for (int c = 2; c <= 3; c++) begin
      drive(0, 3'b101, 0, 0, 0);
      chk($sformatf("lock_c%0d_status", c), 64'(status()), 64'(8'b1_000_000_0));
      chk_fields($sformatf("lock_c%0d", c), 2);
    end
    drive(0, 3'b101, 1, 0, 0);
    chk("lock_c4_status", 64'(status()), 64'(8'b1_100_000_0));
    chk_fields("lock_c4", 2);
    drive(0, 3'b001, 1, 0, 0);
    chk("lock_c5_status", 64'(status()), 64'(8'b1_001_000_0));
    chk_fields("lock_c5", 0);

    // Random OBI-compliant traffic against the reference model
    drive(1, 3'b000, 0, 0, 0);
    q.delete(); m_ptr = 0; m_held = -1; pend = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      int          s;
      logic [2:0]  eg, ev;
      logic        edr, es, g, v;
      logic [31:0] rd;
      @(negedge clk);
      for (int n = 0; n < 3; n++) begin
        if (!pend[n] && ($urandom_range(0, 9) < 4)) begin
          pend[n] = 1'b1;
          addr[n] = $urandom; wdata[n] = $urandom;
          be[n] = 4'($urandom); we[n] = 1'($urandom);
        end
      end
      g = 1'($urandom); v = ($urandom_range(0, 2) == 0); rd = $urandom;
      rst = 0; req = pend; dev_gnt = g; dev_rvalid = v; dev_rdata = rd;
      #1;
      s = -1;
      if (q.size() < MAXO) begin
        if (m_held >= 0) s = m_held;
        else
          for (int k = 0; k < 3; k++)
            if (s < 0 && pend[(m_ptr + k) % 3]) s = (m_ptr + k) % 3;
      end
      edr = (s >= 0);
      eg = '0; ev = '0;
      if (edr && g) eg[s] = 1'b1;
      if (v && q.size() > 0) ev[q[0]] = 1'b1;
      es = v && (q.size() == 0);
      chk($sformatf("rnd%0d_status", cyc), 64'(status()), 64'({edr, eg, ev, es}));
      chk_fields($sformatf("rnd%0d", cyc), s);
      if (v) chk($sformatf("rnd%0d_rdata", cyc), 64'(rd1), 64'(rd));
      if (v && q.size() > 0) void'(q.pop_front());
      m_held = (edr && !g) ? s : -1;
      if (edr && g) begin
        q.push_back(s);
        m_ptr = (s + 1) % 3;
        pend[s] = 1'b0;
      end
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/obi_mux_3_to_1.md
Name: obi_mux_3_to_1

Overview:
- Arbitrates three OBI controller (master) ports onto one OBI device (slave) port. It is the initiator-side counterpart to the team's 1-to-N OBI demux.
- Typical use: core instruction port, core data port and a debug/DMA master sharing one SRAM or peripheral bus.
- Round-robin arbitration; tracks up to MAX_OUTSTANDING granted transactions in an ID FIFO so responses return to the issuing controller in order.

Parameters:
- MAX_OUTSTANDING, 2, number of granted transactions awaiting rvalid (legal 1..4).
- CNT_W, $clog2(MAX_OUTSTANDING+1), width of the outstanding counter (derived; do not override).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- ctrlN_req_i  in  1  controller N request (N = 0, 1, 2; each port has its own signal).
- ctrlN_gnt_o  out  1  controller N grant.
- ctrlN_addr_i  in  32  controller N address.
- ctrlN_we_i  in  1  controller N write enable.
- ctrlN_be_i  in  4  controller N byte enables.
- ctrlN_wdata_i  in  32  controller N write data.
- ctrlN_rvalid_o  out  1  controller N response valid.
- ctrlN_rdata_o  out  32  controller N read data.
- dev_req_o  out  1  device request.
- dev_gnt_i  in  1  device grant.
- dev_addr_o  out  32  muxed address.
- dev_we_o  out  1  muxed write enable.
- dev_be_o  out  4  muxed byte enables.
- dev_wdata_o  out  32  muxed write data.
- dev_rvalid_i  in  1  device response valid.
- dev_rdata_i  in  32  device read data.
- spurious_rvalid_o  out  1  pulse: dev_rvalid_i seen while no transaction is outstanding.

Behaviour:
- Reset (rst_i=1 at clock edge):
  - round-robin pointer = 0; lock = 0; ID FIFO empty; outstanding count = 0.
  - Outputs during and after reset: all ctrlN_gnt_o = 0, all ctrlN_rvalid_o = 0, dev_req_o = 0, spurious_rvalid_o = 0.
- Full condition: full = (count == MAX_OUTSTANDING).
  - While full: dev_req_o = 0 and all ctrlN_gnt_o = 0.
  - No push-while-pop bypass, so there is no rvalid->req combinational path.
- Arbitration (combinational, when not full and not locked):
  - Scan requesters starting at pointer: pointer, pointer+1, pointer+2, wrapping mod 3.
  - The first port with req=1 becomes sel.
  - If no controller is requesting, dev_req_o = 0.
- Lock:
  - If dev_req_o=1 and dev_gnt_i=0, register lock=1 and hold sel next cycle. OBI requires the address phase to stay stable until grant.
  - Lock clears on the accepted handshake.
- Address phase:
  - dev_req_o = ctrl[sel]_req_i.
  - dev_addr/we/be/wdata = ctrl[sel] fields; all zero when nothing is selected.
  - ctrl[sel]_gnt_o = dev_gnt_i; every other ctrlN_gnt_o = 0.
  - Zero-latency combinational path from request to grant.
- Accept = dev_req_o & dev_gnt_i. On accept:
  - push sel onto the ID FIFO;
  - count += 1;
  - pointer <= (sel + 1) mod 3.
- Response phase:
  - ctrl[head]_rvalid_o = dev_rvalid_i when FIFO is non-empty; other rvalids = 0.
  - dev_rdata_i is broadcast to all ctrlN_rdata_o.
  - dev_rvalid_i with FIFO non-empty: pop; count -= 1.
- Simultaneous accept and rvalid in the same cycle (not full): push and pop both occur; count unchanged; head advances.
- Same-cycle response: rvalid in the same cycle as the accepting grant is not supported. The response must come at least one cycle after grant, per OBI.
- dev_rvalid_i while FIFO empty:
  - no state change;
  - spurious_rvalid_o = 1 combinationally for that cycle;
  - all ctrlN_rvalid_o = 0.
- Wrap-around: FIFO read/write pointers wrap modulo MAX_OUTSTANDING. Count never exceeds MAX_OUTSTANDING or underflows.
- Reset mid-operation: outstanding IDs are discarded. Later device rvalids flag spurious_rvalid_o; the system must reset the device too.

Decomposition:
- Shared package obi_pkg: OBI field widths (ADDR_W=32, DATA_W=32, BE_W=4) and a port-ID type (2 bits).
- One sub-module: obi_mux_id_fifo.
  - Synchronous FIFO of 2-bit IDs, depth MAX_OUTSTANDING.
  - push/pop/full/empty/head ports; sync active-high reset.
  - Same clock and reset as the parent.

Test Plan:
- Single master read: ctrl1 req, addr 0x1000, dev_gnt_i=1; rvalid 2 cycles later with rdata 0xCAFEF00D -> ctrl1_gnt_o=1 in the request cycle; ctrl1_rvalid_o=1 with 0xCAFEF00D; other rvalids stay 0.
- Round-robin: all three req every cycle, dev_gnt_i=1, rvalid each cycle after -> grant order 0,1,2,0,1,2; each rvalid reaches the matching issuer.
- Lock/backpressure: ctrl2 req with dev_gnt_i=0 for 3 cycles; ctrl0 asserts req on cycle 2 -> dev_addr_o stays at ctrl2's address until the grant on cycle 4; ctrl0 is granted next.
- Full stall: MAX_OUTSTANDING=2, two writes granted, no rvalid -> third req sees dev_req_o=0 and gnt=0; after one rvalid, the third is granted the following cycle.
- Spurious: dev_rvalid_i=1 after reset with no requests -> spurious_rvalid_o=1 for 1 cycle; all ctrlN_rvalid_o=0; count stays 0.
- Reset mid-flight: 2 outstanding, rst_i pulsed for 1 cycle -> count=0, pointer=0; the next ctrl1/ctrl2 simultaneous requests are granted ctrl1 first.
